mem_sram_ctrl: RTL and testbench

//  Sits directly below the MEM stage and replaces its behavioural memory array with an external 16-bit asynchronous SRAM.

---
 rtl/mem_sram_pkg.sv | 11 +
 rtl/sram_wait_counter.sv | 33 +++
 rtl/mem_sram_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_sram_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_sram_pkg.sv
// Shared types and default sizing for the MEM-stage SRAM controller.
package mem_sram_pkg;

  localparam int unsigned SRAM_AW     = 18;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int unsigned BASE_ADDR   = 1024;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait timer: loaded on phase entry, flags the final clock of the phase
// and the clock just before it.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = mem_sram_pkg::WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last,
  output logic near_last
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      last      <= 1'b0;
      near_last <= 1'b0;
    end else if (load) begin
      count     <= CW'(WAIT_CYCLES);
      last      <= 1'b0;
      near_last <= (WAIT_CYCLES == 1);
    end else begin
      if (count != '0) count <= count - CW'(1);
      last      <= (count == CW'(1));
      near_last <= (count == CW'(2));
    end
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Splits each 32-bit MEM-stage access into two timed 16-bit accesses on an
// external asynchronous SRAM, stalling the pipeline until the word completes.
module mem_sram_ctrl #(
  parameter int unsigned SRAM_AW     = mem_sram_pkg::SRAM_AW,
  parameter int unsigned WAIT_CYCLES = mem_sram_pkg::WAIT_CYCLES,
  parameter int unsigned BASE_ADDR   = mem_sram_pkg::BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  import mem_sram_pkg::*;

  localparam int unsigned WW = SRAM_AW - 1;

  state_t             state, state_nxt;
  op_t                op_q, op_nxt;
  logic [WW-1:0]      word_q, word_nxt;
  logic [15:0]        wdata_hi_q, wdata_hi_nxt;
  logic [31:0]        rdata_nxt;
  logic [SRAM_AW-1:0] sram_addr_nxt;
  logic [15:0]        dq_out_nxt;
  logic               oe_nxt, we_n_nxt;
  logic               req, load, last, near_last, is_wr;

  assign req   = wr_en | rd_en;
  assign is_wr = (op_q == OP_WR);
  assign ready = ((state == IDLE) && !req) || (state == DONE);
  assign load  = ((state == IDLE) && req) || ((state == LOW) && last);

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .last      (last),
    .near_last (near_last)
  );

  // Next state and next registered SRAM drive; the write strobe releases one clock before phase end.
  always_comb begin
    state_nxt     = state;
    op_nxt        = op_q;
    word_nxt      = word_q;
    wdata_hi_nxt  = wdata_hi_q;
    rdata_nxt     = rdata;
    sram_addr_nxt = sram_addr;
    dq_out_nxt    = sram_dq_out;
    oe_nxt        = sram_dq_oe;
    we_n_nxt      = sram_we_n;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt     = LOW;
          op_nxt        = wr_en ? OP_WR : OP_RD;
          word_nxt      = WW'((address - 32'(BASE_ADDR)) >> 2);
          wdata_hi_nxt  = wdata[31:16];
          sram_addr_nxt = {word_nxt, 1'b0};
          dq_out_nxt    = wdata[15:0];
          oe_nxt        = wr_en;
          we_n_nxt      = !wr_en;
        end
      end
      LOW: begin
        if (last) begin
          if (!is_wr) rdata_nxt[15:0] = sram_dq_in;
          state_nxt     = HIGH;
          sram_addr_nxt = {word_q, 1'b1};
          dq_out_nxt    = wdata_hi_q;
          oe_nxt        = is_wr;
          we_n_nxt      = !is_wr;
        end else begin
          we_n_nxt      = !is_wr || near_last;
        end
      end
      HIGH: begin
        if (last) begin
          if (!is_wr) rdata_nxt[31:16] = sram_dq_in;
          state_nxt     = DONE;
          oe_nxt        = 1'b0;
          we_n_nxt      = 1'b1;
        end else begin
          we_n_nxt      = !is_wr || near_last;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op_q        <= OP_RD;
      word_q      <= '0;
      wdata_hi_q  <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state       <= state_nxt;
      op_q        <= op_nxt;
      word_q      <= word_nxt;
      wdata_hi_q  <= wdata_hi_nxt;
      rdata       <= rdata_nxt;
      sram_addr   <= sram_addr_nxt;
      sram_dq_out <= dq_out_nxt;
      sram_dq_oe  <= oe_nxt;
      sram_we_n   <= we_n_nxt;
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl against a behavioural 16-bit asynchronous SRAM.
module tb_mem_sram_ctrl;

  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned DEPTH   = 1 << SRAM_AW;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               wr_en = 1'b0;
  logic               rd_en = 1'b0;
  logic [31:0]        address = '0;
  logic [31:0]        wdata = '0;
  logic [31:0]        rdata;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model [int unsigned];
  logic [31:0] rdata_exp = '0;

  mem_sram_ctrl #(.SRAM_AW(SRAM_AW), .WAIT_CYCLES(2), .BASE_ADDR(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: a write commits when the strobe is seen released; reset discards a pending strobe
  logic [15:0]        sram [DEPTH];
  logic               pend = 1'b0;
  logic [SRAM_AW-1:0] pend_addr;
  logic [15:0]        pend_data;

  assign sram_dq_in = sram[sram_addr];

  always @(negedge clk or negedge rst) begin
    if (!rst) pend <= 1'b0;
    else if (!sram_we_n) begin
      pend      <= 1'b1;
      pend_addr <= sram_addr;
      pend_data <= sram_dq_out;
    end else if (pend) begin
      sram[pend_addr] <= pend_data;
      pend            <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return (off >> 2) & 32'h0001_FFFF;
  endfunction

  // Scoreboard consumer: every completed access pops one expected rdata
  logic prev_ready = 1'b1;
  always @(negedge clk or negedge rst) begin
    if (!rst) prev_ready = 1'b1;
    else begin
      if (ready && !prev_ready) begin
        done_cnt++;
        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("rdata", rdata, exp_q.pop_front());
      end
      prev_ready = ready;
    end
  end

  task automatic run_access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output int we_even, output int we_odd, output int oe_cyc);
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; wdata = d;
    if (w) model[word_of(a)] = d;
    else if (r) rdata_exp = model.exists(word_of(a)) ? model[word_of(a)] : 32'h0;
    exp_q.push_back(rdata_exp);
    lat = 0; we_even = 0; we_odd = 0; oe_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
      lat++;
      if (!sram_we_n) begin
        if (sram_addr[0]) we_odd++;
        else we_even++;
      end
      if (sram_dq_oe) oe_cyc++;
    end
    check("ready_at_done", 32'(ready), 32'd1);
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int lat, we_e, we_o, oe_c, d0;

    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_dq_out", 32'(sram_dq_out), 32'h0);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    rst = 1'b1;

    // 1: word write
    run_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, lat, we_e, we_o, oe_c);
    check("t1_latency", 32'(lat), 32'd7);
    check("t1_we_low_lo", 32'(we_e), 32'd2);
    check("t1_we_low_hi", 32'(we_o), 32'd2);
    check("t1_oe_cycles", 32'(oe_c), 32'd6);
    go_idle(2);
    check("t1_sram4", 32'(sram[4]), 32'h0000BEEF);
    check("t1_sram5", 32'(sram[5]), 32'h0000DEAD);

    // 2: word read
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, lat, we_e, we_o, oe_c);
    check("t2_latency", 32'(lat), 32'd7);
    check("t2_oe_cycles", 32'(oe_c), 32'd0);
    check("t2_we_low", 32'(we_e + we_o), 32'd0);
    go_idle(2);

    run_access(1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, lat, we_e, we_o, oe_c);
    check("pre3_latency", 32'(lat), 32'd7);
    go_idle(2);

    // 3: read held across DONE, next address presented in the following cycle
    d0 = done_cnt;
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, lat, we_e, we_o, oe_c);
    check("t3a_latency", 32'(lat), 32'd7);
    run_access(1'b0, 1'b1, 32'd1036, 32'h0, lat, we_e, we_o, oe_c);
    check("t3b_latency", 32'(lat), 32'd7);
    go_idle(12);
    check("t3_access_count", 32'(done_cnt - d0), 32'd2);

    // 4: simultaneous write and read request performs the write
    run_access(1'b1, 1'b1, 32'd1024, 32'h12345678, lat, we_e, we_o, oe_c);
    check("t4_latency", 32'(lat), 32'd7);
    check("t4_we_low", 32'(we_e + we_o), 32'd4);
    go_idle(2);
    check("t4_sram0", 32'(sram[0]), 32'h00005678);
    check("t4_sram1", 32'(sram[1]), 32'h00001234);

    // below-base address wraps to the top of the SRAM
    run_access(1'b1, 1'b0, 32'd1020, 32'h0BADC0DE, lat, we_e, we_o, oe_c);
    go_idle(2);
    check("wrap_lo", 32'(sram[DEPTH-2]), 32'h0000C0DE);
    check("wrap_hi", 32'(sram[DEPTH-1]), 32'h00000BAD);
    run_access(1'b0, 1'b1, 32'd1020, 32'h0, lat, we_e, we_o, oe_c);
    go_idle(2);

    // 5: reset during the high-half write strobe
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1024; wdata = 32'hAAAA5555;
    repeat (5) @(negedge clk);
    check("t5_in_high_addr", 32'(sram_addr), 32'd1);
    check("t5_in_high_we_n", 32'(sram_we_n), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_we_n", 32'(sram_we_n), 32'd1);
    check("t5_rst_oe", 32'(sram_dq_oe), 32'd0);
    check("t5_rst_rdata", rdata, 32'h0);
    check("t5_rst_ready_req", 32'(ready), 32'd0);
    wr_en = 1'b0;
    #1;
    check("t5_rst_ready_idle", 32'(ready), 32'd1);
    rst = 1'b1;
    rdata_exp = 32'h0;
    model[word_of(32'd1024)] = 32'h12345555;
    repeat (3) @(negedge clk);
    check("t5_sram0", 32'(sram[0]), 32'h00005555);
    check("t5_sram1", 32'(sram[1]), 32'h00001234);
    check("t5_ready_after", 32'(ready), 32'd1);

    // 6: idle with no request
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_ready", 32'(ready), 32'd1);
      check("t6_we_n", 32'(sram_we_n), 32'd1);
      check("t6_rdata", rdata, rdata_exp);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
